// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared states, opcodes, ALU op codes and control word for the
//            multicycle MIPS controller and the ALU decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BLTEX   = 4'd9,
    ADDIEX  = 4'd10,
    LIEX    = 4'd11,
    IMMWB   = 4'd12,
    JEX     = 4'd13
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLT   = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LI    = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_LI    = 3'b100;

  // memwait marks states that stall on memready; pcwrite/irwrite/retire
  // in those states only take effect once memready is seen.
  typedef struct packed {
    logic       memreq;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       regwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       branch;
    logic       branchlt;
    logic       retire;
    logic       memwait;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_outdec.sv
// ============================================================================
// Module   : mc_outdec
// Brief    : Combinational state-to-control-word decode (Moore outputs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_outdec
  import mips_pkg::*;
(
  input  statetype_t state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memreq  = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.memwait = 1'b1;
      end
      DECODE: ctrl.alusrcb = 2'b11;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD: begin
        ctrl.memreq  = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.memwait = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      MEMWR: begin
        ctrl.memreq   = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.retire   = 1'b1;
        ctrl.memwait  = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
        ctrl.retire  = 1'b1;
      end
      BLTEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_SLT;
        ctrl.pcsrc    = 2'b01;
        ctrl.branchlt = 1'b1;
        ctrl.retire   = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      LIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_LI;
      end
      IMMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
        ctrl.retire  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_mainfsm.sv
// ============================================================================
// Module   : mc_mainfsm
// Brief    : Multicycle MIPS main controller with memory-ready handshake and
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_mainfsm
  import mips_pkg::*;
#(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic            zero,
  input  logic            memready,
  output logic            pcen,
  output logic            irwrite,
  output logic            regwrite,
  output logic            memwrite,
  output logic            memreq,
  output logic            iord,
  output logic            memtoreg,
  output logic            regdst,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [2:0]      aluop,
  output logic            illegal,
  output logic [CNTW-1:0] instret
);

  statetype_t      r_state;
  statetype_t      w_next;
  ctrl_t           w_ctrl;
  logic            w_go;
  logic            w_illegal;
  logic [CNTW-1:0] r_instret;

  mc_outdec u_outdec (
    .state (r_state),
    .ctrl  (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      FETCH:   if (memready) w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_BLT:       w_next = BLTEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_LI:        w_next = LIEX;
          OP_J:         w_next = JEX;
          default: begin
            w_illegal = 1'b1;
            w_next    = FETCH;
          end
        endcase
      end
      MEMADR:  w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (memready) w_next = MEMWB;
      MEMWR:   if (memready) w_next = FETCH;
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = IMMWB;
      LIEX:    w_next = IMMWB;
      default: w_next = FETCH;
    endcase
  end

  // In handshake states the one-shot effects wait for memready.
  assign w_go = ~w_ctrl.memwait | memready;

  always_ff @(posedge clk) begin
    if (reset)                     r_instret <= '0;
    else if (w_ctrl.retire & w_go) r_instret <= r_instret + {{(CNTW-1){1'b0}}, 1'b1};
  end

  assign pcen     = ~reset & ((w_ctrl.pcwrite & w_go) | (w_ctrl.branch & zero)
                              | (w_ctrl.branchlt & ~zero));
  assign irwrite  = ~reset & w_ctrl.irwrite & w_go;
  assign regwrite = ~reset & w_ctrl.regwrite;
  assign memwrite = ~reset & w_ctrl.memwrite;
  assign memreq   = ~reset & w_ctrl.memreq;
  assign illegal  = ~reset & w_illegal;
  assign iord     = w_ctrl.iord;
  assign memtoreg = w_ctrl.memtoreg;
  assign regdst   = w_ctrl.regdst;
  assign alusrca  = w_ctrl.alusrca;
  assign alusrcb  = w_ctrl.alusrcb;
  assign pcsrc    = w_ctrl.pcsrc;
  assign aluop    = w_ctrl.aluop;
  assign instret  = r_instret;

endmodule

`default_nettype wire
